mult_pipe_hs: RTL
=================

// Module: mult_pipe_hs
// PURPOSE
//   Parametrised, stall-capable pipelined integer multiplier for the EX stage.
//   Executes all four RV M-extension multiply ops (MUL, MULH, MULHSU, MULHU) with a
//   valid/ready handshake on both sides, an opaque tag carried alongside each op,
//   and a flush. Sits between issue/RS and the CDB arbiter; accepts one op per
//   cycle and returns XLEN-bit results in issue order.
// PARAMETERS
//   XLEN    32  operand/result width
//   STAGES  4   pipeline depth; must divide 2*XLEN; BPS = 2*XLEN/STAGES mplier bits per stage
//   TAG_W   6   width of tag passed through unchanged (ROB/PRF index)
// PORTS
//   clock       in   1       single clock, all state updates on posedge
//   reset       in   1       synchronous, active-high
//   in_valid    in   1       op presented on in_* this cycle
//   in_ready    out  1       unit accepts op this cycle
//   in_func     in   2       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   in_mcand    in   XLEN    rs1 operand
//   in_mplier   in   XLEN    rs2 operand
//   in_tag      in   TAG_W   passthrough tag
//   flush       in   1       squash every in-flight op
//   out_valid   out  1       result available
//   out_ready   in   1       consumer takes result this cycle
//   out_result  out  XLEN    selected product half
//   out_tag     out  TAG_W   tag of the op in out_result
// BEHAVIOUR
//   Operand extension to 2*XLEN, by func:
//     MUL: both zero-ext; MULH: both sign-ext; MULHSU: mcand sign-ext, mplier zero-ext;
//     MULHU: both zero-ext. All arithmetic is mod 2^(2*XLEN).
//   Stage k (0..STAGES-1) holds {valid, func, tag, mcand, mplier, partial}; it adds
//     mplier[BPS-1:0]*mcand to partial, then shifts mplier right by BPS (zero fill) and
//     mcand left by BPS.
//   Output: MUL -> product[XLEN-1:0]; others -> product[2*XLEN-1:XLEN].
//   Handshake: transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output).
//   Advance rule: stage k loads from stage k-1 iff stage k is empty or stage k itself
//     advances this cycle; the last stage advances iff out_ready. Bubbles collapse.
//   in_ready = !stage0.valid || stage0 advances (combinational from out_ready via chain).
//   out_valid = last stage valid; out_result/out_tag held stable while
//     out_valid && !out_ready.
//   Latency: accept at cycle N -> out_valid at cycle N+STAGES with no backpressure.
//     Throughput 1 op/cycle sustained while out_ready=1.
//   Ordering: results leave strictly in acceptance order; no op dropped or duplicated.
//   Flush: at the next edge all stage valids clear. in_ready is forced 0 in the flush
//     cycle (an in_valid that cycle is not accepted); out_valid of that cycle still
//     counts as transferred only if out_ready=1 (consumer must ignore it on flush).
//   Reset (also mid-operation): every stage valid=0, all datapath regs 0;
//     out_valid=0, out_result=0, out_tag=0, in_ready=1 in the first cycle after reset.
//   Simultaneous in-transfer and out-transfer with a full pipe is legal and keeps it full.
//   Only valid bits need reset for correctness; datapath reset to 0 for determinism.
// TESTING
//   MUL 7*6, tag=3, out_ready=1 -> after 4 cycles out_result=0x0000002A, out_tag=3.
//   MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULH 0x80000000*0x80000000 -> 0x40000000.
//   Stream 8 back-to-back ops, out_ready=0 for 3 cycles mid-stream -> in_ready drops
//     once 4 ops buffered, resumes; 8 results in order, tags 0..7, none lost.
//   Flush with 3 ops in flight plus in_valid=1 -> no out_valid next cycle onward;
//     op issued cycle after flush returns alone with correct result.
//   Assert reset with pipe full -> out_valid=0, out_result=0 next cycle; new op after
//     reset deasserts completes in STAGES cycles; repeat with STAGES=1,2,8.

Source files
------------

// File: rtl/mult_pipe_hs_if.sv
// Handshake bundle for the pipelined multiplier.
//   in_*  : issue side (valid/ready, func, operands, tag)
//   out_* : result side (valid/ready, result, tag)
// master = issue + consumer side, slave = the multiplier.
interface mult_pipe_hs_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_func;
   logic [XLEN-1:0]   in_mcand;
   logic [XLEN-1:0]   in_mplier;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_result;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, in_func, in_mcand, in_mplier, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );

   modport slave (
      input  in_valid, in_func, in_mcand, in_mplier, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
endinterface

// File: rtl/mult_pipe_hs.sv
// Stall-capable pipelined integer multiplier (MUL/MULH/MULHSU/MULHU).
// Each stage retires BPS multiplier bits; results leave in issue order.
// Ports:
//   clock  : single clock, posedge
//   reset  : synchronous, active-high; clears every stage
//   flush  : squash all in-flight ops at the next edge; blocks input this cycle
//   bus    : mult_pipe_hs_if.slave (in_* op handshake, out_* result handshake)
// Note: in_ready is combinational from out_ready through the stall chain.
module mult_pipe_hs #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned STAGES = 4,   // must divide 2*XLEN
   parameter int unsigned TAG_W  = 6
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   mult_pipe_hs_if.slave bus
);

   localparam int unsigned DW  = 2 * XLEN;
   localparam int unsigned BPS = DW / STAGES;

   localparam logic [1:0] FUNC_MUL    = 2'b00;
   localparam logic [1:0] FUNC_MULH   = 2'b01;
   localparam logic [1:0] FUNC_MULHSU = 2'b10;

   typedef struct packed {
      logic             valid;
      logic [1:0]       func;
      logic [TAG_W-1:0] tag;
      logic [DW-1:0]    mcand;
      logic [DW-1:0]    mplier;
      logic [DW-1:0]    partial;
   } stage_t;

   stage_t            stg [STAGES];
   stage_t            nxt [STAGES];
   stage_t            entry;
   logic [STAGES-1:0] load;
   logic              in_ready_c;

   // One radix-2^BPS step: accumulate the low multiplier digit, then realign.
   function automatic stage_t step(input stage_t s);
      stage_t r;
      r         = s;
      r.partial = s.partial + DW'(s.mplier[BPS-1:0]) * s.mcand;
      r.mplier  = s.mplier >> BPS;
      r.mcand   = s.mcand << BPS;
      return r;
   endfunction

   // Stall chain: a stage loads when empty or when its content moves on.
   always_comb begin
      logic adv;
      adv  = bus.out_ready;
      load = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         load[k] = !stg[k].valid || adv;
         adv     = load[k];
      end
   end

   assign in_ready_c   = load[0] && !flush;
   assign bus.in_ready = in_ready_c;

   // Operand extension to 2*XLEN by function.
   always_comb begin
      logic mcand_sx;
      logic mplier_sx;
      mcand_sx      = (bus.in_func == FUNC_MULH) || (bus.in_func == FUNC_MULHSU);
      mplier_sx     = (bus.in_func == FUNC_MULH);
      entry         = '0;
      entry.valid   = bus.in_valid && in_ready_c;
      entry.func    = bus.in_func;
      entry.tag     = bus.in_tag;
      entry.mcand   = {{XLEN{mcand_sx && bus.in_mcand[XLEN-1]}}, bus.in_mcand};
      entry.mplier  = {{XLEN{mplier_sx && bus.in_mplier[XLEN-1]}}, bus.in_mplier};
      entry.partial = '0;
   end

   // Each register captures the result of its own step.
   always_comb begin
      nxt[0] = step(entry);
      for (int k = 1; k < int'(STAGES); k++) begin
         nxt[k] = step(stg[k-1]);
      end
   end

   // Pipeline registers; flush only drops valids, datapath is don't-care.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            stg[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (flush) begin
               stg[k].valid <= 1'b0;
            end else if (load[k]) begin
               stg[k] <= nxt[k];
            end
         end
      end
   end

   assign bus.out_valid  = stg[STAGES-1].valid;
   assign bus.out_tag    = stg[STAGES-1].tag;
   assign bus.out_result = (stg[STAGES-1].func == FUNC_MUL) ?
                           stg[STAGES-1].partial[XLEN-1:0] :
                           stg[STAGES-1].partial[DW-1:XLEN];

endmodule
